adc3664_spi_cfg_master: RTL and testbench

//  Upstream SPI master feeding the ADC3664 SPI slave port. Buffers register commands
//  in a FIFO and serialises each one as a 24-bit frame on SEN/SDIO, clocked by the

---
 rtl/adc3664_spi_cfg_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_adc3664_spi_cfg_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc3664_spi_cfg_master.sv
`timescale 1ns/1ps
// adc3664_spi_cfg_master
//   Upstream SPI master for the ADC3664 configuration port. Register commands
//   are queued in a small FIFO and each one is shifted out MSB first as a
//   24-bit frame {rw, 3'b000, addr[11:0], data[7:0]} while SEN is low.
//   Every state update happens on the falling edge of the free-running SCLK,
//   so the slave sees stable data on each rising edge.
//
//   Optional feature macro: ADC_SPI_READBACK_EN
//     defined     - read frames release SDIO (sdio_oe=0) for the 8 data bits,
//                   capture sdio_in MSB first and report it on rd_data with
//                   a rd_valid pulse alongside frame_done.
//     not defined - every frame is driven for all 24 bits; rd_data and
//                   rd_valid stay 0 and sdio_in is ignored.
//
// Ports
//   SCLK        in   SPI clock, state changes on its falling edge
//   Reset       in   asynchronous active-high reset
//   cmd_valid   in   command offered
//   cmd_ready   out  FIFO not full
//   cmd_rw      in   0 = write, 1 = read
//   cmd_addr    in   12-bit register address
//   cmd_data    in   8-bit write data
//   SEN         out  serial enable, active low
//   sdio_out    out  serial data to the slave
//   sdio_oe     out  1 = master drives SDIO
//   sdio_in     in   serial data from the slave
//   busy        out  frame, gap or queued command pending
//   frame_done  out  one-period pulse after the last bit of a frame
//   rd_data     out  last captured read byte
//   rd_valid    out  one-period pulse when rd_data is updated
//   fifo_level  out  FIFO occupancy, 0..FIFO_DEPTH
module adc3664_spi_cfg_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        SCLK,
  input  logic                        Reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [11:0]                 cmd_addr,
  input  logic [7:0]                  cmd_data,
  output logic                        SEN,
  output logic                        sdio_out,
  output logic                        sdio_oe,
  input  logic                        sdio_in,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_C    = LW'(FIFO_DEPTH);
  localparam logic [3:0]    GAP_C      = 4'(GAP_CYCLES);
  localparam logic [4:0]    LAST_BIT   = 5'd23;
  localparam logic [4:0]    DATA_START = 5'd16;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [20:0]   mem_q [FIFO_DEPTH];
  logic [23:0]   frame_q, frame_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          sen_q, sen_d;
  logic          sdio_out_q, sdio_out_d;
  logic          sdio_oe_q, sdio_oe_d;
  logic          frame_done_q, frame_done_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          push, pop, launch;
  logic [20:0]   head;
  logic [23:0]   head_frame;

`ifdef ADC_SPI_READBACK_EN
  logic          is_read_q, is_read_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
`else
  logic          unused_sdio_in;
  assign unused_sdio_in = sdio_in;
`endif

  // Stored entries are {rw, addr, data}; the three zero bits are added here.
  assign head       = mem_q[rd_ptr_q];
  assign head_frame = {head[20], 3'b000, head[19:0]};

  assign cmd_ready  = (count_q != DEPTH_C);
  assign fifo_level = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign SEN        = sen_q;
  assign sdio_out   = sdio_out_q;
  assign sdio_oe    = sdio_oe_q;
  assign frame_done = frame_done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_d      = frame_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sen_d        = sen_q;
    sdio_out_d   = sdio_out_q;
    sdio_oe_d    = sdio_oe_q;
    frame_done_d = 1'b0;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
`ifdef ADC_SPI_READBACK_EN
    is_read_d    = is_read_q;
    rx_shift_d   = rx_shift_q;
`endif
    push   = cmd_valid && cmd_ready;
    pop    = 1'b0;
    launch = 1'b0;

    case (state_q)
      IDLE: launch = (count_q != '0);
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d      = GAP;
          gap_cnt_d    = '0;
          sen_d        = 1'b1;
          sdio_out_d   = 1'b0;
          sdio_oe_d    = 1'b0;
          frame_done_d = 1'b1;
`ifdef ADC_SPI_READBACK_EN
          if (is_read_q) begin
            rd_data_d  = {rx_shift_q[6:0], sdio_in};
            rd_valid_d = 1'b1;
          end
`endif
        end else begin
          bit_cnt_d  = bit_cnt_q + 5'd1;
          frame_d    = {frame_q[22:0], 1'b0};
          sdio_out_d = frame_q[22];
`ifdef ADC_SPI_READBACK_EN
          // The slave owns SDIO for the data byte of a read frame.
          if (is_read_q && (bit_cnt_d >= DATA_START)) begin
            sdio_out_d = 1'b0;
            sdio_oe_d  = 1'b0;
          end
`endif
        end
`ifdef ADC_SPI_READBACK_EN
        // Slave launches on the rising edge, so the falling edge ending each
        // data period is a safe sample point.
        if (is_read_q && (bit_cnt_q >= DATA_START))
          rx_shift_d = {rx_shift_q[6:0], sdio_in};
`endif
      end
      GAP: begin
        // Frame-end edge plus GAP_CYCLES further edges keeps SEN high for
        // GAP_CYCLES+1 periods before the next launch.
        if (gap_cnt_q == GAP_C) begin
          launch = (count_q != '0);
          if (!launch) state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      pop        = 1'b1;
      state_d    = SHIFT;
      sen_d      = 1'b0;
      sdio_out_d = head_frame[23];
      sdio_oe_d  = 1'b1;
      bit_cnt_d  = '0;
      frame_d    = head_frame;
`ifdef ADC_SPI_READBACK_EN
      is_read_d  = head[20];
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(negedge SCLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sen_q        <= 1'b1;
      sdio_out_q   <= 1'b0;
      sdio_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
`ifdef ADC_SPI_READBACK_EN
      is_read_q    <= 1'b0;
      rx_shift_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sen_q        <= sen_d;
      sdio_out_q   <= sdio_out_d;
      sdio_oe_q    <= sdio_oe_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
`ifdef ADC_SPI_READBACK_EN
      is_read_q    <= is_read_d;
      rx_shift_q   <= rx_shift_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(negedge SCLK) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_data};
  end

endmodule

// File: tb/tb_adc3664_spi_cfg_master.sv
`timescale 1ns/1ps
// Directed bench for adc3664_spi_cfg_master. Two instances share the command
// bus: u_dut uses GAP_CYCLES=2 and u_dut_g0 uses GAP_CYCLES=0. Outputs are
// sampled and inputs changed on the rising SCLK edge, away from the falling
// edge the design updates on; the rising edge is also where the slave samples.
module tb_adc3664_spi_cfg_master;

  logic       SCLK = 1'b0;
  logic       Reset;
  logic       cmd_valid, cmd_valid0, cmd_rw, sdio_in;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_data;

  logic       cmd_ready, sen, sdio_out, sdio_oe, busy, frame_done, rd_valid;
  logic [7:0] rd_data;
  logic [2:0] fifo_level;

  logic       cmd_ready0, sen0, sdio_out0, sdio_oe0, busy0, frame_done0, rd_valid0;
  logic [7:0] rd_data0;
  logic [2:0] fifo_level0;

  logic       sel_g0;
  logic       mon_sen, mon_out, mon_oe, mon_done, mon_rdv;
  logic [7:0] mon_rdd;

  int checks = 0;
  int errors = 0;

  logic [23:0] cap_bits;
  int          cap_len, cap_oe_low, cap_pre_high, cap_in_done, cap_rdv_cnt;
  logic        cap_done_end, cap_rdv_end;
  logic [7:0]  cap_rdd_end;

  logic [7:0]  slave_mem [4096];
  logic [23:0] exp_frames [5];
  logic        exp_ready [6];
  logic [2:0]  exp_level [6];
  logic [11:0] t2_addr [6];
  logic [7:0]  t2_data [6];

  always #5 SCLK = ~SCLK;

  adc3664_spi_cfg_master #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) u_dut (
    .SCLK(SCLK), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .SEN(sen),
    .sdio_out(sdio_out), .sdio_oe(sdio_oe), .sdio_in(sdio_in), .busy(busy),
    .frame_done(frame_done), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_level(fifo_level)
  );

  adc3664_spi_cfg_master #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) u_dut_g0 (
    .SCLK(SCLK), .Reset(Reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .SEN(sen0),
    .sdio_out(sdio_out0), .sdio_oe(sdio_oe0), .sdio_in(sdio_in), .busy(busy0),
    .frame_done(frame_done0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .fifo_level(fifo_level0)
  );

  // Route whichever instance is under test to the frame capture task.
  always_comb begin
    mon_sen  = sel_g0 ? sen0        : sen;
    mon_out  = sel_g0 ? sdio_out0   : sdio_out;
    mon_oe   = sel_g0 ? sdio_oe0    : sdio_oe;
    mon_done = sel_g0 ? frame_done0 : frame_done;
    mon_rdv  = sel_g0 ? rd_valid0   : rd_valid;
    mon_rdd  = sel_g0 ? rd_data0    : rd_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called on a rising edge: offers one command to u_dut for one edge.
  task automatic applyStimulus(input logic rw, input logic [11:0] addr, input logic [7:0] data);
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge SCLK);
    cmd_valid = 1'b0;
  endtask

  // Waits for SEN low, records every bit the slave would sample, acts as the
  // slave on SDIO whenever the master releases it, and returns on the first
  // SEN-high rising edge after the frame. All waits are bounded.
  task automatic captureFrame(input logic [7:0] slave_byte);
    int guard;
    int k;
    cap_bits = '0; cap_len = 0; cap_oe_low = 0; cap_pre_high = 0;
    cap_in_done = 0; cap_rdv_cnt = 0; guard = 0; k = 0;
    @(posedge SCLK);
    while (mon_sen !== 1'b0 && guard < 200) begin
      cap_pre_high++;
      if (mon_done === 1'b1) cap_in_done++;
      if (mon_rdv === 1'b1) cap_rdv_cnt++;
      guard++;
      @(posedge SCLK);
    end
    while (mon_sen === 1'b0 && cap_len < 40) begin
      cap_bits = {cap_bits[22:0], mon_out};
      cap_len++;
      if (mon_done === 1'b1) cap_in_done++;
      if (mon_rdv === 1'b1) cap_rdv_cnt++;
      if (mon_oe === 1'b0 && k < 8) begin
        cap_oe_low++;
        sdio_in = slave_byte[3'(7 - k)];
        k++;
      end else begin
        sdio_in = 1'b0;
      end
      @(posedge SCLK);
    end
    sdio_in      = 1'b0;
    cap_done_end = mon_done;
    cap_rdv_end  = mon_rdv;
    cap_rdd_end  = mon_rdd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n_done;
    int n_senlow;
    Reset = 1'b1; cmd_valid = 1'b0; cmd_valid0 = 1'b0; cmd_rw = 1'b0;
    cmd_addr = '0; cmd_data = '0; sdio_in = 1'b0; sel_g0 = 1'b0;
    for (int i = 0; i < 4096; i++) slave_mem[i] = 8'h00;
    exp_frames[0] = 24'h000111; exp_frames[1] = 24'h07FFFF; exp_frames[2] = 24'h080000;
    exp_frames[3] = 24'h045678; exp_frames[4] = 24'h0ABCDE;
    t2_addr[0] = 12'h001; t2_data[0] = 8'h11; t2_addr[1] = 12'h7FF; t2_data[1] = 8'hFF;
    t2_addr[2] = 12'h800; t2_data[2] = 8'h00; t2_addr[3] = 12'h456; t2_data[3] = 8'h78;
    t2_addr[4] = 12'hABC; t2_data[4] = 8'hDE; t2_addr[5] = 12'hFFF; t2_data[5] = 8'h01;
    exp_ready[0] = 1'b1; exp_ready[1] = 1'b1; exp_ready[2] = 1'b1;
    exp_ready[3] = 1'b1; exp_ready[4] = 1'b1; exp_ready[5] = 1'b0;
    exp_level[0] = 3'd0; exp_level[1] = 3'd1; exp_level[2] = 3'd1;
    exp_level[3] = 3'd2; exp_level[4] = 3'd3; exp_level[5] = 3'd4;

    // Reset values while Reset is held.
    repeat (3) @(posedge SCLK);
    checkOutput("rst_sen", 32'(sen), 32'd1);
    checkOutput("rst_sdio_out", 32'(sdio_out), 32'd0);
    checkOutput("rst_sdio_oe", 32'(sdio_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_sen_g0", 32'(sen0), 32'd1);
    Reset = 1'b0;
    @(posedge SCLK);
    checkOutput("rel_sen", 32'(sen), 32'd1);
    checkOutput("rel_busy", 32'(busy), 32'd0);

    // Single write 0x0A5 <= 0x3C.
    applyStimulus(1'b0, 12'h0A5, 8'h3C);
    checkOutput("t1_level", 32'(fifo_level), 32'd1);
    checkOutput("t1_sen_before", 32'(sen), 32'd1);
    captureFrame(8'h00);
    checkOutput("t1_latency", 32'(cap_pre_high), 32'd0);
    checkOutput("t1_bits", 32'(cap_bits), 32'h00A53C);
    checkOutput("t1_len", 32'(cap_len), 32'd24);
    checkOutput("t1_oe_low", 32'(cap_oe_low), 32'd0);
    checkOutput("t1_done_early", 32'(cap_in_done), 32'd0);
    checkOutput("t1_done_end", 32'(cap_done_end), 32'd1);
    if (cap_len == 24 && cap_bits[23] == 1'b0) slave_mem[cap_bits[19:8]] = cap_bits[7:0];
    checkOutput("t1_slave_reg", 32'(slave_mem[12'h0A5]), 32'h3C);
    repeat (3) @(posedge SCLK);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Six pushes on consecutive edges into a 4-deep FIFO: five accepted.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          checkOutput($sformatf("t2_ready%0d", i), 32'(cmd_ready), 32'(exp_ready[i]));
          checkOutput($sformatf("t2_level%0d", i), 32'(fifo_level), 32'(exp_level[i]));
          cmd_rw = 1'b0; cmd_addr = t2_addr[i]; cmd_data = t2_data[i]; cmd_valid = 1'b1;
          @(posedge SCLK);
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          captureFrame(8'h00);
          checkOutput($sformatf("t2_bits%0d", f), 32'(cap_bits), 32'(exp_frames[f]));
          checkOutput($sformatf("t2_len%0d", f), 32'(cap_len), 32'd24);
          checkOutput($sformatf("t2_done_end%0d", f), 32'(cap_done_end), 32'd1);
          checkOutput($sformatf("t2_done_early%0d", f), 32'(cap_in_done), 32'd0);
          if (f == 0) checkOutput("t2_latency", 32'(cap_pre_high), 32'd1);
          else checkOutput($sformatf("t2_gap%0d", f), 32'(cap_pre_high + 1), 32'd3);
        end
      end
    join
    repeat (2) @(posedge SCLK);
    checkOutput("t2_busy_in_gap", 32'(busy), 32'd1);
    @(posedge SCLK);
    checkOutput("t2_busy_drop", 32'(busy), 32'd0);
    checkOutput("t2_level_end", 32'(fifo_level), 32'd0);

    // Reset at bit_cnt=10 with two commands still queued.
    cmd_rw = 1'b0; cmd_addr = 12'h111; cmd_data = 8'h22; cmd_valid = 1'b1;
    @(posedge SCLK);
    cmd_addr = 12'h333; cmd_data = 8'h44;
    @(posedge SCLK);
    cmd_addr = 12'h555; cmd_data = 8'h66;
    @(posedge SCLK);
    cmd_valid = 1'b0;
    repeat (9) @(posedge SCLK);
    checkOutput("t3_sen_mid", 32'(sen), 32'd0);
    checkOutput("t3_level_mid", 32'(fifo_level), 32'd2);
    Reset = 1'b1;
    #1;
    checkOutput("t3_sen_async", 32'(sen), 32'd1);
    checkOutput("t3_oe_async", 32'(sdio_oe), 32'd0);
    checkOutput("t3_level_async", 32'(fifo_level), 32'd0);
    checkOutput("t3_ready_async", 32'(cmd_ready), 32'd1);
    checkOutput("t3_busy_async", 32'(busy), 32'd0);
    @(posedge SCLK);
    Reset = 1'b0;
    n_done = 0;
    n_senlow = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge SCLK);
      if (frame_done === 1'b1) n_done++;
      if (sen !== 1'b1) n_senlow++;
    end
    checkOutput("t3_no_done", 32'(n_done), 32'd0);
    checkOutput("t3_no_frames", 32'(n_senlow), 32'd0);
    applyStimulus(1'b0, 12'h3C3, 8'hA5);
    captureFrame(8'h00);
    checkOutput("t3_bits_after", 32'(cap_bits), 32'h03C3A5);
    checkOutput("t3_len_after", 32'(cap_len), 32'd24);
    checkOutput("t3_done_after", 32'(cap_done_end), 32'd1);
    repeat (3) @(posedge SCLK);

    // Read of 0x123; the slave answers 0xA7 when given the bus.
    applyStimulus(1'b1, 12'h123, 8'h5A);
    captureFrame(8'hA7);
    checkOutput("t4_len", 32'(cap_len), 32'd24);
    checkOutput("t4_done_end", 32'(cap_done_end), 32'd1);
    checkOutput("t4_rdv_early", 32'(cap_rdv_cnt), 32'd0);
`ifdef ADC_SPI_READBACK_EN
    checkOutput("t4_header", 32'(cap_bits[23:8]), 32'h8123);
    checkOutput("t4_oe_low", 32'(cap_oe_low), 32'd8);
    checkOutput("t4_rd_valid", 32'(cap_rdv_end), 32'd1);
    checkOutput("t4_rd_data", 32'(cap_rdd_end), 32'hA7);
    @(posedge SCLK);
    checkOutput("t4_rd_valid_pulse", 32'(rd_valid), 32'd0);
    checkOutput("t4_rd_data_hold", 32'(rd_data), 32'hA7);
`else
    checkOutput("t5_bits", 32'(cap_bits), 32'h81235A);
    checkOutput("t5_oe_low", 32'(cap_oe_low), 32'd0);
    checkOutput("t5_rd_valid", 32'(cap_rdv_end), 32'd0);
    checkOutput("t5_rd_data", 32'(cap_rdd_end), 32'h0);
    @(posedge SCLK);
    checkOutput("t5_rd_valid_after", 32'(rd_valid), 32'd0);
`endif
    repeat (3) @(posedge SCLK);

    // GAP_CYCLES=0 instance: two back-to-back writes, one SEN-high period.
    sel_g0 = 1'b1;
    fork
      begin
        cmd_rw = 1'b0; cmd_addr = 12'h0F0; cmd_data = 8'h0F; cmd_valid0 = 1'b1;
        @(posedge SCLK);
        cmd_addr = 12'h00F; cmd_data = 8'hF0;
        @(posedge SCLK);
        cmd_valid0 = 1'b0;
      end
      begin
        captureFrame(8'h00);
        checkOutput("t6_bits0", 32'(cap_bits), 32'h00F00F);
        checkOutput("t6_len0", 32'(cap_len), 32'd24);
        checkOutput("t6_latency", 32'(cap_pre_high), 32'd1);
        checkOutput("t6_done_end0", 32'(cap_done_end), 32'd1);
        captureFrame(8'h00);
        checkOutput("t6_bits1", 32'(cap_bits), 32'h000FF0);
        checkOutput("t6_len1", 32'(cap_len), 32'd24);
        checkOutput("t6_gap", 32'(cap_pre_high + 1), 32'd1);
        checkOutput("t6_done_early1", 32'(cap_in_done), 32'd0);
        checkOutput("t6_done_end1", 32'(cap_done_end), 32'd1);
      end
    join
    @(posedge SCLK);
    checkOutput("t6_busy_drop", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
